// File: rtl/fractal_sync_node.sv
// Fractal sync tree node: merges two child sync requests, resolves them locally or forwards them to the parent, and fans the wake back down.
// Wake arrives 2 cycles after the last capture; no backpressure. FSYNC_NODE_TIMEOUT_EN adds a timeout for a lone pending child.
module fractal_sync_node #(
  parameter int unsigned LVL_W       = 4,
  parameter int unsigned NODE_LVL    = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [1:0]            c_sync_i,
  input  logic [1:0][LVL_W-1:0] c_level_i,
  output logic [1:0]            c_wake_o,
  output logic [1:0]            c_error_o,
  input  logic [1:0]            c_ack_i,
  output logic                  p_sync_o,
  output logic [LVL_W-1:0]      p_level_o,
  input  logic                  p_wake_i,
  input  logic                  p_error_i,
  output logic                  p_ack_o
);

  typedef enum logic [1:0] {IDLE, FWD, WAIT_P, WAKE} state_e;

  localparam logic [LVL_W-1:0] NODE_LVL_L = LVL_W'(NODE_LVL);

  state_e                  state_q;
  logic [1:0]              pend_q, pend_d;
  logic [1:0][LVL_W-1:0]   lvl_q, lvl_d;
  logic [1:0]              acked_q, acked_d;
  logic                    fwd_q;
  logic [1:0]              wake_q, err_q, err_d;
  logic                    p_sync_q, p_ack_q;
  logic [LVL_W-1:0]        p_level_q;

  logic [1:0] legal, illegal, tmo_clr;
  logic       both_pend, same_lvl, idle_mis, idle_loc, idle_fwd;
  logic       wp_wake, wp_err, enter_wake, pend_drop;
  logic [1:0] acked_nxt;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      legal[i]   = c_sync_i[i] & ~pend_q[i] & (c_level_i[i] >= NODE_LVL_L);
      illegal[i] = c_sync_i[i] & ~legal[i];
    end
  end

  assign both_pend  = &pend_q;
  assign same_lvl   = (lvl_q[0] == lvl_q[1]);
  assign idle_mis   = (state_q == IDLE) & both_pend & ~same_lvl;
  assign idle_loc   = (state_q == IDLE) & both_pend & same_lvl & (lvl_q[0] == NODE_LVL_L);
  assign idle_fwd   = (state_q == IDLE) & both_pend & same_lvl & (lvl_q[0] > NODE_LVL_L);
  assign wp_wake    = (state_q == WAIT_P) & p_wake_i;
  assign wp_err     = (state_q == WAIT_P) & p_error_i & ~p_wake_i;
  assign enter_wake = idle_loc | wp_wake;
  assign pend_drop  = idle_mis | wp_err | enter_wake;
  assign acked_nxt  = acked_q | c_ack_i;

`ifdef FSYNC_NODE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lone, tmo_fire;

  // Count only while a single child waits in IDLE; any other pend pattern restarts it.
  assign lone     = (state_q == IDLE) & (^pend_q);
  assign tmo_fire = lone & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign cnt_d    = (lone & ~tmo_fire) ? cnt_q + CNT_W'(1) : '0;
  assign tmo_clr  = {2{tmo_fire}} & pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end
`else
  assign tmo_clr = 2'b00;
`endif

  always_comb begin
    pend_d = (pend_q & ~{2{pend_drop}} & ~tmo_clr) | legal;
    for (int i = 0; i < 2; i++) begin
      lvl_d[i] = legal[i] ? c_level_i[i] : lvl_q[i];
    end
    acked_d = acked_q;
    if (state_q == WAKE) acked_d = (&acked_q) ? 2'b00 : acked_nxt;
    err_d = illegal | {2{idle_mis | wp_err}} | tmo_clr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      lvl_q     <= '0;
      acked_q   <= '0;
      fwd_q     <= 1'b0;
      wake_q    <= '0;
      err_q     <= '0;
      p_sync_q  <= 1'b0;
      p_level_q <= '0;
      p_ack_q   <= 1'b0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      lvl_q     <= '0;
      acked_q   <= '0;
      fwd_q     <= 1'b0;
      wake_q    <= '0;
      err_q     <= '0;
      p_sync_q  <= 1'b0;
      p_level_q <= '0;
      p_ack_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      lvl_q     <= lvl_d;
      acked_q   <= acked_d;
      err_q     <= err_d;
      p_sync_q  <= 1'b0;
      p_level_q <= '0;
      p_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_loc) begin
            state_q <= WAKE;
            wake_q  <= 2'b11;
            fwd_q   <= 1'b0;
          end else if (idle_fwd) begin
            state_q   <= FWD;
            p_sync_q  <= 1'b1;
            p_level_q <= lvl_q[0];
            fwd_q     <= 1'b1;
          end
        end
        FWD: state_q <= WAIT_P;
        WAIT_P: begin
          if (p_wake_i) begin
            state_q <= WAKE;
            wake_q  <= 2'b11;
          end else if (p_error_i) begin
            state_q <= IDLE;
            fwd_q   <= 1'b0;
          end
        end
        WAKE: begin
          if (&acked_q) begin
            state_q <= IDLE;
            wake_q  <= 2'b00;
            fwd_q   <= 1'b0;
          end else begin
            // Parent ack goes out in the cycle the second child ack is registered.
            wake_q  <= ~acked_nxt;
            p_ack_q <= fwd_q & (&acked_nxt);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_wake_o  = wake_q;
  assign c_error_o = err_q;
  assign p_sync_o  = p_sync_q;
  assign p_level_o = p_level_q;
  assign p_ack_o   = p_ack_q;

endmodule

// File: tb/tb_fractal_sync_node.sv
// Randomized episode bench for fractal_sync_node: expected outputs come from per-episode event timing rules.
module tb_fractal_sync_node;
  localparam int LVL_W    = 4;
  localparam int NODE_LVL = 1;
  localparam int TMO      = 16;
  localparam int N        = 64;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  clear_i = 1'b0;
  logic [1:0]            c_sync_i = '0;
  logic [1:0][LVL_W-1:0] c_level_i = '0;
  logic [1:0]            c_wake_o, c_error_o;
  logic [1:0]            c_ack_i = '0;
  logic                  p_sync_o;
  logic [LVL_W-1:0]      p_level_o;
  logic                  p_wake_i = 1'b0, p_error_i = 1'b0;
  logic                  p_ack_o;

  int n_chk = 0;
  int n_err = 0;

  fractal_sync_node #(.LVL_W(LVL_W), .NODE_LVL(NODE_LVL), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .c_sync_i(c_sync_i), .c_level_i(c_level_i), .c_wake_o(c_wake_o),
    .c_error_o(c_error_o), .c_ack_i(c_ack_i), .p_sync_o(p_sync_o),
    .p_level_o(p_level_o), .p_wake_i(p_wake_i), .p_error_i(p_error_i),
    .p_ack_o(p_ack_o)
  );

  always #5 clk_i = ~clk_i;

  // Per-cycle stimulus schedule and expected outputs for one episode.
  logic [1:0]       s_sync [N];
  logic [LVL_W-1:0] s_lvl  [N][2];
  logic [1:0]       s_ack  [N];
  logic             s_pw [N], s_pe [N], s_clr [N];
  logic [1:0]       e_wake [N], e_err [N];
  logic             e_ps [N], e_pack [N];
  logic [LVL_W-1:0] e_pl [N];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < N; c++) begin
      s_sync[c] = '0; s_lvl[c][0] = '0; s_lvl[c][1] = '0; s_ack[c] = '0;
      s_pw[c] = 0; s_pe[c] = 0; s_clr[c] = 0;
      e_wake[c] = '0; e_err[c] = '0; e_ps[c] = 0; e_pack[c] = 0; e_pl[c] = '0;
    end
  endtask

  task automatic run_sched(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      check("wake",   c_wake_o,  e_wake[c]);
      check("error",  c_error_o, e_err[c]);
      check("p_sync", p_sync_o,  e_ps[c]);
      check("p_lvl",  p_level_o, e_pl[c]);
      check("p_ack",  p_ack_o,   e_pack[c]);
      c_sync_i     = s_sync[c];
      c_level_i[0] = s_lvl[c][0];
      c_level_i[1] = s_lvl[c][1];
      c_ack_i      = s_ack[c];
      p_wake_i     = s_pw[c];
      p_error_i    = s_pe[c];
      clear_i      = s_clr[c];
    end
  endtask

  // resp: 0 = parent wakes, 1 = parent errors. qd: parent delay. ak*: child ack delays after wake.
  task automatic episode(input int l0, input int l1, input int first, input int d,
                         input bit resync, input int resp, input int qd,
                         input int ak0, input int ak1, input bit spur);
    int  s [2];
    int  l [2];
    int  ak [2];
    bit  v [2];
    int  L, R, W, A, endc, r, oth;
    bit  fwd;
    clear_sched();
    l[0] = l0; l[1] = l1; ak[0] = ak0; ak[1] = ak1;
    oth = 1 - first;
    s[first] = 1; s[oth] = 1 + d; L = 1 + d;
    W = -1; fwd = 0; endc = L + 6;
    for (int i = 0; i < 2; i++) begin
      s_sync[s[i]][i] = 1'b1;
      s_lvl[s[i]][i]  = LVL_W'(l[i]);
      v[i] = (l[i] >= NODE_LVL);
      if (!v[i]) e_err[s[i]+1][i] = 1'b1;
    end
    if (spur) begin
      s_pw[0] = 1'b1;
      s_pe[0] = 1'($urandom_range(0, 1));
    end
    if (resync && v[first] && d >= 2) begin
      r = s[first] + 1 + $urandom_range(0, d - 2);
      s_sync[r][first] = 1'b1;
      s_lvl[r][first]  = LVL_W'($urandom_range(0, 3));
      e_err[r+1][first] = 1'b1;
    end
    if (v[0] && v[1]) begin
      if (l0 != l1) begin
        e_err[L+2] = 2'b11;
        endc = L + 5;
      end else if (l0 == NODE_LVL) begin
        W = L + 2;
      end else begin
        e_ps[L+2] = 1'b1;
        e_pl[L+2] = LVL_W'(l0);
        R = L + 3 + qd;
        if (resp == 1) begin
          s_pe[R] = 1'b1;
          e_err[R+1] = 2'b11;
          endc = R + 4;
        end else begin
          s_pw[R] = 1'b1;
          W = R + 1;
          fwd = 1;
        end
      end
    end
    if (W >= 0) begin
      A = 0;
      for (int i = 0; i < 2; i++) begin
        s_ack[W+ak[i]][i] = 1'b1;
        for (int c = W; c <= W + ak[i]; c++) e_wake[c][i] = 1'b1;
        if (W + ak[i] > A) A = W + ak[i];
      end
      if (fwd) e_pack[A+1] = 1'b1;
      endc = A + 4;
    end
    s_clr[endc] = 1'b1;
    run_sched(endc + 1);
  endtask

  initial begin
    int nerr0, nwake, first_err;

    @(negedge clk_i);
    check("rst_wake",  c_wake_o,  0);
    check("rst_error", c_error_o, 0);
    check("rst_psync", p_sync_o,  0);
    check("rst_pack",  p_ack_o,   0);
    rst_ni = 1'b1;

    episode(1, 1, 0, 0, 0, 0, 0, 1, 2, 0);   // local, simultaneous
    episode(2, 2, 0, 5, 0, 0, 2, 0, 3, 0);   // forwarded, parent wake
    episode(1, 2, 0, 3, 0, 0, 0, 0, 0, 0);   // level mismatch
    episode(0, 1, 0, 2, 0, 0, 0, 0, 0, 0);   // level 0, lone partner
    episode(2, 2, 0, 4, 1, 0, 1, 2, 0, 1);   // resync while pending
    episode(3, 3, 1, 1, 0, 1, 3, 0, 0, 1);   // forwarded, parent error

    // Clear in the middle of a local wake.
    clear_sched();
    s_sync[1] = 2'b11; s_lvl[1][0] = 1; s_lvl[1][1] = 1;
    e_wake[3] = 2'b11; e_wake[4] = 2'b11;
    s_clr[4] = 1'b1;
    run_sched(9);

    for (int k = 0; k < 40; k++) begin
      episode($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              1'($urandom_range(0, 1)));
    end

    // Lone child: timeout error when enabled, indefinite wait otherwise.
    nerr0 = 0; nwake = 0; first_err = -1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk_i);
      if (c_error_o[0]) begin
        nerr0++;
        if (first_err < 0) first_err = c;
      end
      if (c_wake_o != 2'b00 || c_error_o[1] || p_sync_o) nwake++;
      c_sync_i     = (c == 1) ? 2'b01 : 2'b00;
      c_level_i[0] = (c == 1) ? LVL_W'(1) : '0;
    end
`ifdef FSYNC_NODE_TIMEOUT_EN
    check("tmo_count", nerr0, 1);
    check("tmo_window", int'(first_err >= TMO + 1 && first_err <= TMO + 2), 1);
`else
    check("no_tmo_err", nerr0, 0);
`endif
    check("lone_quiet", nwake, 0);
    @(negedge clk_i); clear_i = 1'b1;
    @(negedge clk_i); clear_i = 1'b0;
    episode(1, 1, 1, 2, 0, 0, 0, 3, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
